// File: rtl/spi_reg_bank_pkg.sv
// Shared address map, reset values and write-select decode for spi_reg_bank.
package spi_reg_bank_pkg;

   localparam logic [2:0] ADDR_CTRL     = 3'd0;
   localparam logic [2:0] ADDR_PULSE    = 3'd1;
   localparam logic [2:0] ADDR_FLAGS    = 3'd2;
   localparam logic [2:0] ADDR_MASK     = 3'd3;
   localparam logic [2:0] ADDR_SCRATCH0 = 3'd4;

   localparam int unsigned NUM_SCRATCH = 4;

   localparam logic [7:0] RST_CTRL    = 8'h00;
   localparam logic [7:0] RST_MASK    = 8'h00;
   localparam logic [7:0] RST_SCRATCH = 8'h00;
   localparam logic [7:0] RST_FLAGS   = 8'h00;

   // One-hot write select; bit position equals the register address.
   typedef struct packed {
      logic scratch3;
      logic scratch2;
      logic scratch1;
      logic scratch0;
      logic mask;
      logic flags;
      logic pulse;
      logic ctrl;
   } wr_sel_t;

   function automatic wr_sel_t decode_wr(input logic [2:0] addr, input logic en);
      logic [7:0] onehot_s;
      if (en) begin
         onehot_s = 8'h01 << addr;
      end else begin
         onehot_s = 8'h00;
      end
      return wr_sel_t'(onehot_s);
   endfunction

endpackage

// File: rtl/spi_reg_bank_irq.sv
// Event edge detect, sticky W1C flags and registered irq/status.
// SPI_REG_BANK_EVT_SYNC_EN adds a 2-flop synchroniser ahead of the edge detect.
module spi_reg_bank_irq
   import spi_reg_bank_pkg::*;
#(
   parameter int unsigned REG_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             ena,
   input  logic [REG_W-1:0] evt_i,
   input  logic             w1c_en,
   input  logic [REG_W-1:0] w1c_data,
   input  logic [REG_W-1:0] mask,
   output logic [REG_W-1:0] flags,
   output logic [REG_W-1:0] flags_nxt,
   output logic             irq,
   output logic [7:0]       status
);

   localparam logic [REG_W-1:0] ZERO = {REG_W{1'b0}};

   logic [REG_W-1:0] evt_s;
   logic [REG_W-1:0] evt_prev_r;
   logic [REG_W-1:0] rise_s;
   logic [REG_W-1:0] clr_s;
   logic [REG_W-1:0] flags_r;
   logic [REG_W-1:0] masked_s;
   logic             irq_r;
   logic [7:0]       status_r;

`ifdef SPI_REG_BANK_EVT_SYNC_EN
   logic [REG_W-1:0] sync1_r;
   logic [REG_W-1:0] sync2_r;

   // Two-stage synchroniser for asynchronous event inputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_r <= ZERO;
         sync2_r <= ZERO;
      end else if (ena) begin
         sync1_r <= evt_i;
         sync2_r <= sync1_r;
      end
   end

   assign evt_s = sync2_r;
`else
   assign evt_s = evt_i;
`endif

   assign rise_s   = evt_s & ~evt_prev_r;
   assign clr_s    = w1c_en ? w1c_data : ZERO;
   // OR-ing the rise last makes a same-cycle set beat the clear.
   assign flags_nxt = (flags_r & ~clr_s) | rise_s;
   assign masked_s  = flags_r & mask;

   // Edge history, sticky flags and the lagging irq/status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         evt_prev_r <= ZERO;
         flags_r    <= REG_W'(RST_FLAGS);
         irq_r      <= 1'b0;
         status_r   <= 8'h00;
      end else if (ena) begin
         evt_prev_r <= evt_s;
         flags_r    <= flags_nxt;
         irq_r      <= |masked_s;
         status_r   <= {|masked_s, masked_s[6:0]};
      end
   end

   assign flags  = flags_r;
   assign irq    = irq_r;
   assign status = status_r;

endmodule

// File: rtl/spi_reg_bank.sv
// Register bank behind the SPI register-access slave: decode, CTRL/PULSE/MASK/SCRATCH, read mux.
// Optional build macro SPI_REG_BANK_EVT_SYNC_EN (see spi_reg_bank_irq).
module spi_reg_bank
   import spi_reg_bank_pkg::*;
#(
   parameter int unsigned ADDR_W = 3,
   parameter int unsigned REG_W  = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ena,
   input  logic [ADDR_W-1:0] reg_addr,
   input  logic [REG_W-1:0]  reg_data_w,
   input  logic              reg_data_dv,
   output logic [REG_W-1:0]  reg_data_r,
   output logic [7:0]        status,
   output logic [REG_W-1:0]  ctrl_o,
   output logic [REG_W-1:0]  pulse_o,
   input  logic [REG_W-1:0]  evt_i,
   output logic              irq_o
);

   localparam logic [REG_W-1:0] ZERO = {REG_W{1'b0}};

   logic             addr_mapped_s;
   logic [2:0]       addr_lo_s;
   wr_sel_t          wr_sel_s;
   logic [7:0]       wr_vec_s;

   logic [REG_W-1:0] ctrl_r;
   logic [REG_W-1:0] mask_r;
   logic [REG_W-1:0] pulse_r;
   logic [REG_W-1:0] rd_r;
   logic [REG_W-1:0] scratch_r     [NUM_SCRATCH];
   logic [REG_W-1:0] scratch_nxt_s [NUM_SCRATCH];

   logic [REG_W-1:0] ctrl_nxt_s;
   logic [REG_W-1:0] mask_nxt_s;
   logic [REG_W-1:0] pulse_nxt_s;
   logic [REG_W-1:0] flags_s;
   logic [REG_W-1:0] flags_nxt_s;
   logic [REG_W-1:0] rd_nxt_s;

   generate
      if (ADDR_W > 3) begin : g_wide_addr
         assign addr_mapped_s = (reg_addr[ADDR_W-1:3] == {(ADDR_W-3){1'b0}});
      end else begin : g_narrow_addr
         assign addr_mapped_s = 1'b1;
      end
   endgenerate

   assign addr_lo_s = reg_addr[2:0];
   assign wr_sel_s  = decode_wr(addr_lo_s, reg_data_dv & addr_mapped_s);
   assign wr_vec_s  = wr_sel_s;

   assign ctrl_nxt_s  = wr_sel_s.ctrl  ? reg_data_w : ctrl_r;
   assign mask_nxt_s  = wr_sel_s.mask  ? reg_data_w : mask_r;
   assign pulse_nxt_s = wr_sel_s.pulse ? reg_data_w : ZERO;

   // Post-write scratch values, so reads see a same-cycle write.
   always_comb begin
      for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
         if (wr_vec_s[int'(ADDR_SCRATCH0) + i]) begin
            scratch_nxt_s[i] = reg_data_w;
         end else begin
            scratch_nxt_s[i] = scratch_r[i];
         end
      end
   end

   // Read mux over post-write values; PULSE and unmapped addresses read zero.
   always_comb begin
      rd_nxt_s = ZERO;
      if (addr_mapped_s) begin
         case (addr_lo_s)
            ADDR_CTRL:                 rd_nxt_s = ctrl_nxt_s;
            ADDR_PULSE:                rd_nxt_s = ZERO;
            ADDR_FLAGS:                rd_nxt_s = flags_nxt_s;
            ADDR_MASK:                 rd_nxt_s = mask_nxt_s;
            3'd4, 3'd5, 3'd6, 3'd7:    rd_nxt_s = scratch_nxt_s[addr_lo_s[1:0]];
            default:                   rd_nxt_s = ZERO;
         endcase
      end else begin
         rd_nxt_s = ZERO;
      end
   end

   // Control, mask, scratch, pulse and read-data registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl_r  <= REG_W'(RST_CTRL);
         mask_r  <= REG_W'(RST_MASK);
         pulse_r <= ZERO;
         rd_r    <= ZERO;
         for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            scratch_r[i] <= REG_W'(RST_SCRATCH);
         end
      end else if (ena) begin
         ctrl_r  <= ctrl_nxt_s;
         mask_r  <= mask_nxt_s;
         pulse_r <= pulse_nxt_s;
         rd_r    <= rd_nxt_s;
         for (int i = 0; i < int'(NUM_SCRATCH); i++) begin
            scratch_r[i] <= scratch_nxt_s[i];
         end
      end
   end

   spi_reg_bank_irq #(
      .REG_W (REG_W)
   ) u_irq (
      .clk       (clk),
      .rst       (rst),
      .ena       (ena),
      .evt_i     (evt_i),
      .w1c_en    (wr_sel_s.flags),
      .w1c_data  (reg_data_w),
      .mask      (mask_r),
      .flags     (flags_s),
      .flags_nxt (flags_nxt_s),
      .irq       (irq_o),
      .status    (status)
   );

   assign reg_data_r = rd_r;
   assign ctrl_o     = ctrl_r;
   assign pulse_o    = pulse_r;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Randomized self-checking bench for spi_reg_bank against an array-based register model.
module tb_spi_reg_bank;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic       ena = 1'b0;
   logic [2:0] reg_addr = 3'd0;
   logic [7:0] reg_data_w = 8'h00;
   logic       reg_data_dv = 1'b0;
   logic [7:0] evt_i = 8'h00;
   logic [7:0] reg_data_r;
   logic [7:0] status;
   logic [7:0] ctrl_o;
   logic [7:0] pulse_o;
   logic       irq_o;

   int n_tests = 0;
   int n_fail  = 0;
   bit chk_en  = 1'b0;

   // Model state: m_reg indexed by address (0 CTRL, 2 FLAGS, 3 MASK, 4..7 SCRATCH).
   logic [7:0] m_reg [8];
   logic [7:0] m_pulse, m_rd, m_status, m_prev, m_s1, m_s2;
   logic       m_irq;

   spi_reg_bank dut (
      .clk         (clk),
      .rst         (rst),
      .ena         (ena),
      .reg_addr    (reg_addr),
      .reg_data_w  (reg_data_w),
      .reg_data_dv (reg_data_dv),
      .reg_data_r  (reg_data_r),
      .status      (status),
      .ctrl_o      (ctrl_o),
      .pulse_o     (pulse_o),
      .evt_i       (evt_i),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [7:0] got, input logic [7:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_reg[i] = 8'h00;
      m_pulse = 8'h00; m_rd = 8'h00; m_status = 8'h00; m_irq = 1'b0;
      m_prev = 8'h00; m_s1 = 8'h00; m_s2 = 8'h00;
   endtask

   // One clock edge of the register bank, straight from the register map rules.
   task automatic model_step();
      logic [7:0] masked, seen, rise;
      if (rst) begin
         model_reset();
      end else if (ena) begin
         masked = m_reg[2] & m_reg[3];
`ifdef SPI_REG_BANK_EVT_SYNC_EN
         seen = m_s2; m_s2 = m_s1; m_s1 = evt_i;
`else
         seen = evt_i;
`endif
         rise   = seen & ~m_prev;
         m_prev = seen;
         m_irq    = |masked;
         m_status = {m_irq, masked[6:0]};
         m_pulse  = 8'h00;
         if (reg_data_dv) begin
            if (reg_addr == 3'd1) m_pulse = reg_data_w;
            else if (reg_addr == 3'd2) m_reg[2] = m_reg[2] & ~reg_data_w;
            else m_reg[reg_addr] = reg_data_w;
         end
         m_reg[2] = m_reg[2] | rise;
         m_rd = (reg_addr == 3'd1) ? 8'h00 : m_reg[reg_addr];
      end
   endtask

   // Drive one cycle of inputs, step the model at the edge, return just after the next falling edge.
   task automatic cycle(input logic e, input logic [2:0] a, input logic [7:0] w,
                        input logic d, input logic [7:0] ev);
      ena = e; reg_addr = a; reg_data_w = w; reg_data_dv = d; evt_i = ev;
      @(posedge clk);
      model_step();
      @(negedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if (chk_en) begin
         check("rd",     reg_data_r,     m_rd);
         check("status", status,         m_status);
         check("ctrl",   ctrl_o,         m_reg[0]);
         check("pulse",  pulse_o,        m_pulse);
         check("irq",    {7'd0, irq_o},  {7'd0, m_irq});
      end
   end

   initial begin
      logic [7:0] ev;
      model_reset();
      #2 rst = 1'b1;
      #1;
      check("rst_ctrl",   ctrl_o,        8'h00);
      check("rst_rd",     reg_data_r,    8'h00);
      check("rst_status", status,        8'h00);
      check("rst_pulse",  pulse_o,       8'h00);
      check("rst_irq",    {7'd0, irq_o}, 8'h00);
      chk_en = 1'b1;
      @(negedge clk); #1;
      rst = 1'b0;

      // 1: CTRL write and read-back
      cycle(1'b1, 3'd0, 8'h5A, 1'b1, 8'h00);
      check("t1_ctrl", ctrl_o, 8'h5A);
      check("t1_rd",   reg_data_r, 8'h5A);
      // 2: PULSE one-shot, reads zero
      cycle(1'b1, 3'd1, 8'h81, 1'b1, 8'h00);
      check("t2_pulse", pulse_o, 8'h81);
      check("t2_rd",    reg_data_r, 8'h00);
      cycle(1'b1, 3'd1, 8'h00, 1'b0, 8'h00);
      check("t2_pulse_end", pulse_o, 8'h00);
      // 3: masked event raises irq, W1C clears it
      cycle(1'b1, 3'd3, 8'h04, 1'b1, 8'h00);
      cycle(1'b1, 3'd0, 8'h00, 1'b0, 8'h04);
      cycle(1'b1, 3'd2, 8'h00, 1'b0, 8'h04);
      check("t3_flags",  reg_data_r, 8'h04);
      check("t3_irq",    {7'd0, irq_o}, 8'h01);
      check("t3_status", status, 8'h84);
      cycle(1'b1, 3'd2, 8'h04, 1'b1, 8'h04);
      check("t3_w1c_rd", reg_data_r, 8'h00);
      cycle(1'b1, 3'd2, 8'h00, 1'b0, 8'h04);
      check("t3_irq_clr", {7'd0, irq_o}, 8'h00);
      check("t3_status_clr", status, 8'h00);
      // 4: same-cycle rise and W1C on bit 3, set wins
      cycle(1'b1, 3'd2, 8'h08, 1'b1, 8'h0C);
      check("t4_set_wins", reg_data_r, 8'h08);
      // 5: strobe with ena low is dropped
      cycle(1'b0, 3'd4, 8'hFF, 1'b1, 8'h0C);
      check("t5_pulse", pulse_o, 8'h00);
      cycle(1'b1, 3'd4, 8'h00, 1'b0, 8'h0C);
      check("t5_scratch", reg_data_r, 8'h00);
      // 6: asynchronous reset in the middle of a pulse
      cycle(1'b1, 3'd0, 8'h5A, 1'b1, 8'h0C);
      cycle(1'b1, 3'd1, 8'h33, 1'b1, 8'h0C);
      check("t6_pre_ctrl",  ctrl_o, 8'h5A);
      check("t6_pre_pulse", pulse_o, 8'h33);
      #2 rst = 1'b1;
      model_reset();
      #1;
      check("t6_ctrl",   ctrl_o, 8'h00);
      check("t6_pulse",  pulse_o, 8'h00);
      check("t6_rd",     reg_data_r, 8'h00);
      check("t6_status", status, 8'h00);
      @(negedge clk); #1;
      rst = 1'b0;
      cycle(1'b1, 3'd0, 8'h00, 1'b0, 8'h0C);
      check("t6_rd_after", reg_data_r, 8'h00);

      // Random traffic, with occasional synchronous-looking reset pulses.
      ev = 8'h00;
      for (int i = 0; i < 2000; i++) begin
         if ($urandom_range(0, 3) == 0) ev = ev ^ (8'h01 << $urandom_range(0, 7));
         rst = ($urandom_range(0, 299) == 0);
         cycle($urandom_range(0, 7) != 0, 3'($urandom_range(0, 7)), 8'($urandom),
               $urandom_range(0, 2) == 0, ev);
      end
      rst = 1'b0;

      chk_en = 1'b0;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
